int_preg_release_unit: RTL and testbench

//   Commit-side reclaim path for the integer physical-register free list. Takes up to two retiring

---
 rtl/int_preg_release_unit.sv | 112 +++++++++++
 tb/tb_int_preg_release_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_preg_release_unit.sv
//------------------------------------------------------------------------------
// Module      : int_preg_release_unit
// Description : Buffers physical-register tags released at commit (two per
//               cycle) and drains them one per cycle into the free list.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module int_preg_release_unit #(
    parameter int PREGWIDE = 5,
    parameter int RELDEEP  = 4,
    parameter int RELCNTW  = 3
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                Commit0Valid,
    input  logic [PREGWIDE-1:0] Commit0Preg,
    input  logic                Commit1Valid,
    input  logic [PREGWIDE-1:0] Commit1Preg,
    output logic                RelStall,
    input  logic                FlushReq,
    input  logic                FreeReady,
    output logic                FreeWable,
    output logic [PREGWIDE-1:0] FreeDin,
    output logic                FreeClean,
    output logic [RELCNTW-1:0]  RelCount
);

    localparam int                 c_PTRW      = $clog2(RELDEEP);
    localparam logic [RELCNTW-1:0] c_STALL_LVL = RELCNTW'(RELDEEP - 2);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PREGWIDE-1:0] r_buf [RELDEEP];
    logic [c_PTRW-1:0]   r_head;
    logic [c_PTRW-1:0]   r_tail;
    logic [RELCNTW-1:0]  r_count;

    logic                w_run;
    logic                w_stall;
    logic                w_enq_ok;
    logic                w_acc0;
    logic                w_acc1;
    logic                w_deq;
    logic [RELCNTW-1:0]  w_nenq;
    logic [c_PTRW-1:0]   w_tail1;

    // Stalling above RELDEEP-2 guarantees room for a full dual-slot commit.
    assign w_run    = (r_state == RUN);
    assign w_stall  = ~w_run | (r_count > c_STALL_LVL);
    assign w_enq_ok = w_run & ~FlushReq & ~w_stall;
    assign w_acc0   = w_enq_ok & Commit0Valid & (Commit0Preg != '0);
    assign w_acc1   = w_enq_ok & Commit1Valid & (Commit1Preg != '0);
    assign w_nenq   = RELCNTW'(w_acc0) + RELCNTW'(w_acc1);
    assign w_deq    = w_run & (r_count != '0) & FreeReady;
    assign w_tail1  = r_tail + c_PTRW'(w_acc0);

    assign RelStall  = w_stall;
    assign FreeWable = w_deq;
    assign FreeDin   = r_buf[r_head];
    assign FreeClean = (r_state == FLUSH);
    assign RelCount  = r_count;

    always_comb begin
        w_state_next = RUN;
        if (FlushReq) begin
            w_state_next = FLUSH;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            for (int i = 0; i < RELDEEP; i++) begin
                r_buf[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (FlushReq) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_acc0) begin
                r_buf[r_tail] <= Commit0Preg;
            end
            // Slot 1 lands right after slot 0 only when slot 0 was accepted.
            if (w_acc1) begin
                r_buf[w_tail1] <= Commit1Preg;
            end
            r_tail  <= r_tail + c_PTRW'(w_nenq);
            r_head  <= r_head + c_PTRW'(w_deq);
            r_count <= r_count + w_nenq - RELCNTW'(w_deq);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_int_preg_release_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_int_preg_release_unit
// Description : Scoreboard bench for int_preg_release_unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_int_preg_release_unit;

    localparam int PREGWIDE = 5;
    localparam int RELDEEP  = 4;
    localparam int RELCNTW  = 3;

    logic                Clk = 1'b0;
    logic                Rest;
    logic                Commit0Valid;
    logic [PREGWIDE-1:0] Commit0Preg;
    logic                Commit1Valid;
    logic [PREGWIDE-1:0] Commit1Preg;
    logic                RelStall;
    logic                FlushReq;
    logic                FreeReady;
    logic                FreeWable;
    logic [PREGWIDE-1:0] FreeDin;
    logic                FreeClean;
    logic [RELCNTW-1:0]  RelCount;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    logic mon_en = 1'b0;

    int_preg_release_unit #(
        .PREGWIDE(PREGWIDE),
        .RELDEEP (RELDEEP),
        .RELCNTW (RELCNTW)
    ) dut (
        .Clk         (Clk),
        .Rest        (Rest),
        .Commit0Valid(Commit0Valid),
        .Commit0Preg (Commit0Preg),
        .Commit1Valid(Commit1Valid),
        .Commit1Preg (Commit1Preg),
        .RelStall    (RelStall),
        .FlushReq    (FlushReq),
        .FreeReady   (FreeReady),
        .FreeWable   (FreeWable),
        .FreeDin     (FreeDin),
        .FreeClean   (FreeClean),
        .RelCount    (RelCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present inputs for one cycle, then return 1ns after the capturing edge.
    task automatic drive(input logic v0, input int p0, input logic v1, input int p1,
                         input logic fr, input logic fl);
        Commit0Valid = v0;
        Commit0Preg  = PREGWIDE'(p0);
        Commit1Valid = v1;
        Commit1Preg  = PREGWIDE'(p1);
        FreeReady    = fr;
        FlushReq     = fl;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input logic fr);
        drive(1'b0, 0, 1'b0, 0, fr, 1'b0);
    endtask

    // Monitor: every free-list write must match the next expected tag.
    always @(negedge Clk) begin
        if (mon_en && FreeWable) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got tag %0d expected no write", FreeDin);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(FreeDin) != e) begin
                    errors++;
                    $display("FAIL write_tag: got %0d expected %0d", FreeDin, e);
                end
            end
        end
    end

    initial begin
        int tag;
        int cyc;

        Rest = 1'b1;
        Commit0Valid = 1'b0; Commit0Preg = '0;
        Commit1Valid = 1'b0; Commit1Preg = '0;
        FlushReq = 1'b0; FreeReady = 1'b0;

        // 1: reset
        @(posedge Clk); @(posedge Clk); #1;
        chk("rst_count", int'(RelCount), 0);
        chk("rst_wable", int'(FreeWable), 0);
        chk("rst_clean", int'(FreeClean), 0);
        chk("rst_stall", int'(RelStall), 0);
        chk("rst_din",   int'(FreeDin), 0);
        Rest = 1'b0;
        mon_en = 1'b1;

        // 2: dual commit, drained 3 then 7
        exp_q.push_back(3); exp_q.push_back(7);
        drive(1'b1, 3, 1'b1, 7, 1'b1, 1'b0);
        chk("dual_din1",   int'(FreeDin), 3);
        chk("dual_wable1", int'(FreeWable), 1);
        chk("dual_count1", int'(RelCount), 2);
        idle(1'b1);
        chk("dual_din2",   int'(FreeDin), 7);
        chk("dual_wable2", int'(FreeWable), 1);
        idle(1'b1);
        chk("dual_wable3", int'(FreeWable), 0);
        chk("dual_count3", int'(RelCount), 0);

        // 3: tag 0 filtered
        exp_q.push_back(9);
        drive(1'b1, 0, 1'b1, 9, 1'b0, 1'b0);
        chk("tag0_count", int'(RelCount), 1);
        chk("tag0_din",   int'(FreeDin), 9);
        idle(1'b1);
        chk("tag0_drained", int'(RelCount), 0);

        // 4: fill, stall, dropped pair, ordered drain
        drive(1'b1, 2, 1'b1, 4, 1'b0, 1'b0);
        chk("full_count2", int'(RelCount), 2);
        chk("full_stall2", int'(RelStall), 0);
        drive(1'b1, 6, 1'b1, 8, 1'b0, 1'b0);
        chk("full_count4", int'(RelCount), 4);
        chk("full_stall4", int'(RelStall), 1);
        drive(1'b1, 20, 1'b1, 21, 1'b0, 1'b0);
        chk("full_drop", int'(RelCount), 4);
        exp_q.push_back(2); exp_q.push_back(4);
        exp_q.push_back(6); exp_q.push_back(8);
        idle(1'b1);
        chk("full_count3", int'(RelCount), 3);
        chk("full_stall3", int'(RelStall), 1);
        idle(1'b1);
        chk("full_count2b", int'(RelCount), 2);
        chk("full_stall2b", int'(RelStall), 0);
        idle(1'b1);
        idle(1'b1);
        chk("full_empty", int'(RelCount), 0);

        // 5: single commits 1..10 with FreeReady toggling, across wrap
        tag = 1;
        cyc = 0;
        while (tag <= 10 && cyc < 100) begin
            if (!RelStall) begin
                exp_q.push_back(tag);
                drive(1'b1, tag, 1'b0, 0, 1'(cyc % 2), 1'b0);
                tag++;
            end else begin
                idle(1'(cyc % 2));
            end
            cyc++;
        end
        chk("wrap_issued", tag, 11);
        cyc = 0;
        while (RelCount != 0 && cyc < 20) begin
            idle(1'b1);
            cyc++;
        end
        chk("wrap_count", int'(RelCount), 0);
        chk("wrap_queue", exp_q.size(), 0);

        // 6: flush discards 11,12 and the concurrent 13
        drive(1'b1, 11, 1'b1, 12, 1'b0, 1'b0);
        chk("fl_count2", int'(RelCount), 2);
        drive(1'b1, 13, 1'b0, 0, 1'b0, 1'b1);
        FlushReq  = 1'b0;
        FreeReady = 1'b1;
        #1;
        chk("fl_clean", int'(FreeClean), 1);
        chk("fl_stall", int'(RelStall), 1);
        chk("fl_wable", int'(FreeWable), 0);
        chk("fl_count", int'(RelCount), 0);
        idle(1'b1);
        chk("fl_clean_off", int'(FreeClean), 0);
        chk("fl_stall_off", int'(RelStall), 0);
        chk("fl_wable_off", int'(FreeWable), 0);

        // back-to-back flush keeps FreeClean high
        drive(1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
        chk("b2b_clean1", int'(FreeClean), 1);
        drive(1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
        chk("b2b_clean2", int'(FreeClean), 1);
        idle(1'b1);
        chk("b2b_clean_off", int'(FreeClean), 0);

        // reset discards buffered tags
        drive(1'b1, 14, 1'b1, 15, 1'b0, 1'b0);
        chk("rst2_count_pre", int'(RelCount), 2);
        Rest = 1'b1;
        idle(1'b0);
        Rest = 1'b0;
        chk("rst2_count", int'(RelCount), 0);
        chk("rst2_din",   int'(FreeDin), 0);
        idle(1'b1);
        idle(1'b1);
        chk("end_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
